// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the two-master RAM bus arbiter.
package ram_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef logic master_idx_t;

    localparam master_idx_t M0 = 1'b0;
    localparam master_idx_t M1 = 1'b1;

    // Word accesses only: the two byte-offset bits must be zero.
    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the master not granted last wins.
module rr_pick2
    import ram_bus_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t last,
    output logic        grant,
    output master_idx_t idx
);

    // Winner selection from the request vector and the last-granted index.
    always_comb begin
        grant = |req;
        idx   = M0;
        case (req)
            2'b01:   idx = M0;
            2'b10:   idx = M1;
            2'b11:   idx = (last == M0) ? M1 : M0;
            default: idx = M0;
        endcase
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for a single-ported RAM slave with misalignment and timeout aborts.
module ram_bus_arbiter
    import ram_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_cs,
    output logic              s_rw,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    master_idx_t       last_r;
    master_idx_t       cur_idx_r;
    master_idx_t       pick_idx_s;
    master_idx_t       win_idx_s;
    logic              pick_valid_s;
    logic              sel_rw_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              start_ok_s;
    logic              start_bad_s;
    logic              done_ok_s;
    logic              done_to_s;
    logic              finish_s;
    logic              m0_ack_d_s;
    logic              m1_ack_d_s;
    logic              err_d_s;
    logic [DATA_W-1:0] rdata_d_s;
    logic              s_cs_d_s;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_r),
        .grant (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign sel_rw_s    = (pick_idx_s == M1) ? m1_rw    : m0_rw;
    assign sel_addr_s  = (pick_idx_s == M1) ? m1_addr  : m0_addr;
    assign sel_wdata_s = (pick_idx_s == M1) ? m1_wdata : m0_wdata;

    // Timeout fires in the cycle the count already equals TIMEOUT and s_ready is still low.
    assign start_ok_s  = (state_r == ST_IDLE) && pick_valid_s && addr_aligned(sel_addr_s[1:0]);
    assign start_bad_s = (state_r == ST_IDLE) && pick_valid_s && !addr_aligned(sel_addr_s[1:0]);
    assign done_ok_s   = (state_r == ST_ACCESS) && s_ready;
    assign done_to_s   = (state_r == ST_ACCESS) && !s_ready && (cnt_r == CNT_MAX);
    assign finish_s    = start_bad_s | done_ok_s | done_to_s;
    assign win_idx_s   = (state_r == ST_IDLE) ? pick_idx_s : cur_idx_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    next_state_s = ST_ACCESS;
                end else if (start_bad_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (done_ok_s || done_to_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_RELEASE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; only the winner's ack is raised.
    always_comb begin
        m0_ack_d_s = 1'b0;
        m1_ack_d_s = 1'b0;
        err_d_s    = start_bad_s | done_to_s;
        rdata_d_s  = {DATA_W{1'b0}};
        s_cs_d_s   = (next_state_s == ST_ACCESS);
        if (finish_s) begin
            if (win_idx_s == M1) begin
                m1_ack_d_s = 1'b1;
            end else begin
                m0_ack_d_s = 1'b1;
            end
        end else begin
            m0_ack_d_s = 1'b0;
            m1_ack_d_s = 1'b0;
        end
        if (done_ok_s && s_rw) begin
            rdata_d_s = s_rdata;
        end else begin
            rdata_d_s = {DATA_W{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_cs     <= 1'b0;
            busy     <= 1'b0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= {DATA_W{1'b0}};
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= {DATA_W{1'b0}};
        end else begin
            s_cs     <= s_cs_d_s;
            busy     <= (next_state_s != ST_IDLE);
            m0_ack   <= m0_ack_d_s;
            m0_err   <= m0_ack_d_s & err_d_s;
            m0_rdata <= m0_ack_d_s ? rdata_d_s : {DATA_W{1'b0}};
            m1_ack   <= m1_ack_d_s;
            m1_err   <= m1_ack_d_s & err_d_s;
            m1_rdata <= m1_ack_d_s ? rdata_d_s : {DATA_W{1'b0}};
        end
    end

    // Grant bookkeeping, latched slave request and the access cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r    <= M1;
            cur_idx_r <= M0;
            cnt_r     <= {CNT_W{1'b0}};
            s_rw      <= 1'b0;
            s_addr    <= {ADDR_W{1'b0}};
            s_wdata   <= {DATA_W{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && pick_valid_s) begin
                last_r    <= pick_idx_s;
                cur_idx_r <= pick_idx_s;
            end
            if (start_ok_s) begin
                s_rw    <= sel_rw_s;
                s_addr  <= sel_addr_s;
                s_wdata <= sel_wdata_s;
            end
            if ((state_r == ST_ACCESS) && (next_state_s == ST_ACCESS)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small two-cycle RAM slave model.
module tb_ram_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_rw, m0_ack, m0_err;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_rw, m1_ack, m1_err;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        s_cs, s_rw, s_ready, busy;
    logic [15:0] s_addr;
    logic [31:0] s_wdata, s_rdata;

    logic        slave_dead;
    logic [1:0]  wcnt;
    logic [31:0] mem [0:15];

    int n_cmp = 0;
    int n_err = 0;

    ram_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_cs(s_cs), .s_rw(s_rw), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: ready in the third cycle of a select, write committed when ready is raised.
    assign s_rdata = (s_addr == 16'h0010) ? 32'hDEADBEEF : mem[s_addr[5:2]];
    always @(posedge clk) begin
        if (!s_cs || slave_dead) begin
            wcnt    <= 2'd0;
            s_ready <= 1'b0;
        end else if (s_ready) begin
            wcnt    <= 2'd0;
            s_ready <= 1'b0;
        end else if (wcnt == 2'd1) begin
            s_ready <= 1'b1;
            if (!s_rw) mem[s_addr[5:2]] <= s_wdata;
        end else begin
            wcnt <= wcnt + 2'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Single request from one master; waits (bounded) for its ack and checks the result.
    task automatic transact(input bit m, input logic rw, input logic [15:0] addr,
                            input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                            input logic [31:0] exp_rdata, input string tag);
        int n;
        logic ack_seen, err_seen, other_seen;
        logic [31:0] rd;
        n = 0; ack_seen = 1'b0; err_seen = 1'b0; other_seen = 1'b0; rd = 32'h0;
        if (m) begin
            m1_req = 1'b1; m1_rw = rw; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_rw = rw; m0_addr = addr; m0_wdata = wdata;
        end
        while (!ack_seen && n < 40) begin
            step();
            n++;
            other_seen = other_seen | (m ? m0_ack : m1_ack);
            ack_seen   = m ? m1_ack : m0_ack;
            err_seen   = m ? m1_err : m0_err;
            rd         = m ? m1_rdata : m0_rdata;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_err"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_other_ack"}, 32'(other_seen), 32'h0);
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int cyc;
        logic exp_w;

        reset = 1'b1; slave_dead = 1'b0;
        m0_req = 1'b0; m0_rw = 1'b0; m0_addr = 16'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_rw = 1'b0; m1_addr = 16'h0; m1_wdata = 32'h0;
        step();
        m0_req = 1'b1; m0_addr = 16'h0010;
        step();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_s_cs", 32'(s_cs), 32'h0);
        check("rst_s_addr", 32'(s_addr), 32'h0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
        m0_req = 1'b0;
        reset = 1'b0;
        step();

        // m0 read of 0x0010: s_cs cycles 1-3, ack cycle 4
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0010;
        check("rd_c0_busy", 32'(busy), 32'h0);
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("rd_scs_c%0d", c), 32'(s_cs), 32'(c <= 3));
            check($sformatf("rd_ack_c%0d", c), 32'(m0_ack), 32'(c == 4));
            check($sformatf("rd_busy_c%0d", c), 32'(busy), 32'(c <= 4));
            if (c == 1) check("rd_saddr", 32'(s_addr), 32'h0010);
            if (c == 4) begin
                check("rd_err", 32'(m0_err), 32'h0);
                check("rd_rdata", m0_rdata, 32'hDEADBEEF);
                check("rd_m1_ack", 32'(m1_ack), 32'h0);
                m0_req = 1'b0;
            end
            if (c == 5) check("rd_rdata_clr", m0_rdata, 32'h0);
        end

        // Simultaneous writes: m0 acked cycle 4, m1 acked cycle 9
        do_reset();
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0000; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0004; m1_wdata = 32'h22;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("wr_scs_c%0d", c), 32'(s_cs),
                  32'((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            check($sformatf("wr_m0ack_c%0d", c), 32'(m0_ack), 32'(c == 4));
            check($sformatf("wr_m1ack_c%0d", c), 32'(m1_ack), 32'(c == 9));
            if (c == 6) begin
                check("wr_m1_saddr", 32'(s_addr), 32'h0004);
                check("wr_m1_swdata", s_wdata, 32'h22);
            end
            if (c == 4) m0_req = 1'b0;
            if (c == 9) m1_req = 1'b0;
        end
        transact(1'b0, 1'b1, 16'h0000, 32'h0, 4, 1'b0, 32'h11, "rb0");
        transact(1'b1, 1'b1, 16'h0004, 32'h0, 4, 1'b0, 32'h22, "rb1");

        // Misaligned m1 access: error ack in cycle 1, slave untouched
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0006; m1_wdata = 32'h33;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("mis_scs_c%0d", c), 32'(s_cs), 32'h0);
            check($sformatf("mis_ack_c%0d", c), 32'(m1_ack), 32'(c == 1));
            check($sformatf("mis_err_c%0d", c), 32'(m1_err), 32'(c == 1));
            check($sformatf("mis_m0ack_c%0d", c), 32'(m0_ack), 32'h0);
            if (c == 1) m1_req = 1'b0;
        end

        // Dead slave: timeout ack in cycle 18
        slave_dead = 1'b1;
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0010;
        for (int c = 1; c <= 19; c++) begin
            step();
            check($sformatf("to_scs_c%0d", c), 32'(s_cs), 32'(c <= 17));
            check($sformatf("to_ack_c%0d", c), 32'(m0_ack), 32'(c == 18));
            if (c == 18) begin
                check("to_err", 32'(m0_err), 32'h1);
                check("to_rdata", m0_rdata, 32'h0);
                m0_req = 1'b0;
            end
        end
        slave_dead = 1'b0;

        // Reset in cycle 2 of an access
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0010;
        step();
        step();
        check("rsta_scs_c2", 32'(s_cs), 32'h1);
        reset = 1'b1; m0_req = 1'b0;
        step();
        reset = 1'b0;
        check("rsta_scs_c3", 32'(s_cs), 32'h0);
        check("rsta_busy_c3", 32'(busy), 32'h0);
        for (int c = 3; c <= 7; c++) begin
            check($sformatf("rsta_noack_c%0d", c), 32'({m0_ack, m1_ack}), 32'h0);
            step();
        end
        transact(1'b1, 1'b1, 16'h0004, 32'h0, 4, 1'b0, 32'h22, "rsta_next");

        // Both masters requesting continuously: alternate grants every 5 cycles
        do_reset();
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0000;
        m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 16'h0004;
        acks = 0; cyc = 0; exp_w = 1'b0;
        while (acks < 6 && cyc < 60) begin
            step();
            cyc++;
            if (m0_ack || m1_ack) begin
                check("rr_cycle", 32'(cyc), 32'(4 + 5 * acks));
                check("rr_winner", 32'(m1_ack), 32'(exp_w));
                check("rr_both", 32'(m0_ack & m1_ack), 32'h0);
                check("rr_rdata", m1_ack ? m1_rdata : m0_rdata, exp_w ? 32'h22 : 32'h11);
                exp_w = ~exp_w;
                acks++;
            end
        end
        check("rr_count", 32'(acks), 32'd6);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
